clk_div_multi: RTL and testbench

CLK_DIV_MULTI -- requirements
Module: clk_div_multi

---
 rtl/clk_div_pkg.sv | 12 +
 rtl/clk_div_ch.sv | 79 +++++++
 rtl/clk_div_multi.sv | 46 ++++
 tb/tb_clk_div_multi.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int CW_DEF      = 27;
  localparam int DEF_DIV_DEF = 100000000;

  // Channel-select width; a single channel still gets one select bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, active/shadow divisor, tick and square wave.
module clk_div_ch #(
  parameter int CW      = 27,
  parameter int DEF_DIV = 100000000
) (
  input  logic          clk1_s,
  input  logic          rst,
  input  logic          en_i,
  input  logic          ld_i,
  input  logic [CW-1:0] ld_div_i,
  output logic          tick_o,
  output logic          clk_o,
  output logic          pend_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] div_q, div_d;
  logic [CW-1:0] shd_q, shd_d;
  logic          pend_q, pend_d;
  logic          tick_q, tick_d;
  logic          clk_q, clk_d;
  logic [CW-1:0] eff;
  logic          term;

  // A zero divisor behaves as divide-by-one.
  assign eff  = (div_q == '0) ? CW'(1) : div_q;
  // ">=" also catches a counter stranded above a shrunken divisor.
  assign term = en_i && (cnt_q >= eff - CW'(1));

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    if (en_i) begin
      if (term) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        clk_d  = ~clk_q;
        if (pend_q) begin
          div_d  = shd_q;
          pend_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    // A load landing on a terminal edge waits for the next one.
    if (ld_i) begin
      shd_d  = ld_div_i;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk1_s) begin
    if (rst) begin
      cnt_q  <= '0;
      div_q  <= CW'(DEF_DIV);
      shd_q  <= CW'(DEF_DIV);
      pend_q <= 1'b0;
      tick_q <= 1'b0;
      clk_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      tick_q <= tick_d;
      clk_q  <= clk_d;
    end
  end

  assign tick_o = tick_q;
  assign clk_o  = clk_q;
  assign pend_o = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: load decode plus
// one clk_div_ch per channel.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int CW      = CW_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic                  clk1_s,
  input  logic                  rst,
  input  logic [NCH-1:0]        en,
  input  logic                  ld_vld,
  input  logic [ch_w(NCH)-1:0]  ld_ch,
  input  logic [CW-1:0]         ld_div,
  output logic                  ld_rdy,
  output logic [NCH-1:0]        tick,
  output logic [NCH-1:0]        clk,
  output logic [NCH-1:0]        pend
);

  localparam int CHW = ch_w(NCH);

  assign ld_rdy = 1'b1;

  // Out-of-range selects match no channel and are dropped.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic hit;
    assign hit = ld_vld && (ld_ch == CHW'(g));

    clk_div_ch #(
      .CW      (CW),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk1_s   (clk1_s),
      .rst      (rst),
      .en_i     (en[g]),
      .ld_i     (hit),
      .ld_div_i (ld_div),
      .tick_o   (tick[g]),
      .clk_o    (clk[g]),
      .pend_o   (pend[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: expected tick cycles and
// pend/clk samples queued by stimulus, consumed by a monitor.
module tb_clk_div_multi;

  localparam int NCH = 2;
  localparam int CW  = 8;

  logic          clk1_s = 1'b0;
  logic          rst    = 1'b1;
  logic [1:0]    en     = 2'b00;
  logic          ld_vld = 1'b0;
  logic [0:0]    ld_ch  = 1'b0;
  logic [CW-1:0] ld_div = '0;
  logic          ld_rdy;
  logic [1:0]    tick;
  logic [1:0]    clk;
  logic [1:0]    pend;

  int cyc    = 0;
  int base   = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int   cyc;
    int   ch;
    int   kind;
    logic val;
  } chk_t;

  chk_t sq[$];
  int   tq0[$];
  int   tq1[$];

  clk_div_multi #(
    .NCH     (NCH),
    .CW      (CW),
    .DEF_DIV (4)
  ) dut (
    .clk1_s (clk1_s),
    .rst    (rst),
    .en     (en),
    .ld_vld (ld_vld),
    .ld_ch  (ld_ch),
    .ld_div (ld_div),
    .ld_rdy (ld_rdy),
    .tick   (tick),
    .clk    (clk),
    .pend   (pend)
  );

  always #5 clk1_s = ~clk1_s;

  always @(posedge clk1_s) cyc <= cyc + 1;

  function automatic void tk(input int ch, input int k);
    if (ch == 0) tq0.push_back(base + k);
    else         tq1.push_back(base + k);
  endfunction

  function automatic void tkr(input int ch, input int f,
                              input int p, input int l);
    for (int k = f; k <= l; k += p) tk(ch, k);
  endfunction

  function automatic void sc(input int k, input int ch,
                             input int kind, input logic v);
    sq.push_back('{base + k, ch, kind, v});
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk1_s);
  endtask

  task automatic goto(input int k);
    while (cyc < base + k) @(negedge clk1_s);
  endtask

  task automatic rst_and_go(input logic [1:0] e);
    int c0;
    rst    = 1'b1;
    en     = 2'b00;
    ld_vld = 1'b0;
    c0     = cyc;
    for (int ch = 0; ch < NCH; ch++) begin
      sq.push_back('{c0 + 2, ch, 0, 1'b0});
      sq.push_back('{c0 + 2, ch, 1, 1'b0});
    end
    sq.push_back('{c0 + 2, 0, 2, 1'b1});
    step(2);
    rst  = 1'b0;
    en   = e;
    base = cyc;
  endtask

  task automatic load(input int ch, input int v);
    ld_vld = 1'b1;
    ld_ch  = 1'(ch);
    ld_div = CW'(v);
  endtask

  task automatic tick_ch(input int ch, input logic t);
    bit have;
    int exp_c;
    have  = (ch == 0) ? (tq0.size() > 0) : (tq1.size() > 0);
    exp_c = -1;
    if (have) exp_c = (ch == 0) ? tq0[0] : tq1[0];
    if (t === 1'b1) begin
      checks++;
      if (!have) begin
        errors++;
        $display("FAIL tick%0d unexpected at cycle %0d", ch, cyc);
      end else begin
        if (ch == 0) void'(tq0.pop_front());
        else         void'(tq1.pop_front());
        if (exp_c != cyc) begin
          errors++;
          $display("FAIL tick%0d at cycle %0d, expected cycle %0d",
                   ch, cyc, exp_c);
        end
      end
    end else if (have && exp_c < cyc) begin
      if (ch == 0) void'(tq0.pop_front());
      else         void'(tq1.pop_front());
      checks++;
      errors++;
      $display("FAIL tick%0d missing, expected at cycle %0d (now %0d)",
               ch, exp_c, cyc);
    end
  endtask

  always @(negedge clk1_s) begin
    tick_ch(0, tick[0]);
    tick_ch(1, tick[1]);
    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      chk_t c;
      logic act;
      string nm;
      c = sq.pop_front();
      case (c.kind)
        0:       begin act = pend[c.ch]; nm = "pend"; end
        1:       begin act = clk[c.ch];  nm = "clk";  end
        default: begin act = ld_rdy;     nm = "ld_rdy"; end
      endcase
      checks++;
      if (act !== c.val) begin
        errors++;
        $display("FAIL %s[%0d] cycle %0d got %b expected %b",
                 nm, c.ch, cyc, act, c.val);
      end
    end
  end

  initial begin
    step(1);

    // Default divide-by-4 out of reset.
    rst_and_go(2'b11);
    tkr(0, 4, 4, 16);
    tkr(1, 4, 4, 16);
    sc(3, 0, 1, 1'b0);
    sc(4, 0, 1, 1'b1);
    sc(7, 0, 1, 1'b1);
    sc(8, 0, 1, 1'b0);
    sc(12, 0, 1, 1'b1);
    goto(18);

    // Mid-period load of 6 on ch0.
    rst_and_go(2'b11);
    tk(0, 4); tk(0, 8); tk(0, 14); tk(0, 20); tk(0, 26);
    tkr(1, 4, 4, 28);
    sc(5, 0, 0, 1'b0);
    sc(6, 0, 0, 1'b1);
    sc(6, 1, 0, 1'b0);
    sc(7, 0, 0, 1'b1);
    sc(8, 0, 0, 1'b0);
    goto(5);
    load(0, 6);
    step(1);
    ld_vld = 1'b0;
    goto(28);

    // Divisor 0 then 1 on ch1.
    rst_and_go(2'b11);
    tkr(0, 4, 4, 12);
    tkr(1, 4, 1, 14);
    sc(1, 1, 0, 1'b1);
    sc(4, 1, 0, 1'b0);
    sc(4, 1, 1, 1'b1);
    sc(5, 1, 1, 1'b0);
    sc(6, 1, 1, 1'b1);
    sc(9, 1, 0, 1'b1);
    sc(9, 1, 1, 1'b0);
    sc(10, 1, 0, 1'b0);
    sc(10, 1, 1, 1'b1);
    sc(11, 1, 1, 1'b0);
    load(1, 0);
    step(1);
    ld_vld = 1'b0;
    goto(8);
    load(1, 1);
    step(1);
    ld_vld = 1'b0;
    goto(14);

    // Load on terminal edge; back-to-back 5 then 7.
    rst_and_go(2'b11);
    tk(0, 4); tk(0, 8); tk(0, 14); tk(0, 20); tk(0, 26);
    tk(1, 4); tk(1, 8); tk(1, 12); tk(1, 19); tk(1, 26);
    sc(3, 0, 0, 1'b0);
    sc(4, 0, 0, 1'b1);
    sc(7, 0, 0, 1'b1);
    sc(8, 0, 0, 1'b0);
    sc(10, 1, 0, 1'b1);
    sc(11, 1, 0, 1'b1);
    sc(12, 1, 0, 1'b0);
    goto(3);
    load(0, 6);
    step(1);
    ld_vld = 1'b0;
    goto(9);
    load(1, 5);
    step(1);
    load(1, 7);
    step(1);
    ld_vld = 1'b0;
    goto(27);

    // Freeze ch0 for 10 cycles.
    rst_and_go(2'b11);
    tk(0, 4); tk(0, 8); tk(0, 22); tk(0, 26); tk(0, 30);
    tkr(1, 4, 4, 28);
    sc(8, 0, 1, 1'b0);
    sc(15, 0, 1, 1'b0);
    sc(21, 0, 1, 1'b0);
    sc(22, 0, 1, 1'b1);
    goto(9);
    en = 2'b10;
    goto(19);
    en = 2'b11;
    goto(30);

    // Reset discards a pending load.
    rst_and_go(2'b11);
    sc(2, 0, 0, 1'b1);
    goto(1);
    load(0, 6);
    step(1);
    ld_vld = 1'b0;
    rst_and_go(2'b11);
    tkr(0, 4, 4, 8);
    tkr(1, 4, 4, 8);
    sc(4, 0, 1, 1'b1);
    sc(5, 0, 0, 1'b0);
    sc(9, 0, 0, 1'b0);
    goto(9);
    en = 2'b00;
    step(3);

    while (tq0.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL tick0 never seen, expected at cycle %0d", tq0[0]);
      void'(tq0.pop_front());
    end
    while (tq1.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL tick1 never seen, expected at cycle %0d", tq1[0]);
      void'(tq1.pop_front());
    end
    while (sq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL sample never taken, cycle %0d", sq[0].cyc);
      void'(sq.pop_front());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
